// File: rtl/math_pkg.sv
// Shared math-library types and helpers for the multiplier/divider family.
package math_pkg;

    localparam int unsigned DW = 64;

    typedef logic [DW-1:0]   data_t;
    typedef logic [2*DW-1:0] prod_t;

    typedef enum logic {
        IDLE,
        RUN
    } div_state_t;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int unsigned ctr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/div_step_m.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step_m #(
    parameter int unsigned DW = 64
) (
    input  logic [DW-1:0] rem,
    input  logic          in_bit,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] rem_next,
    output logic          q_bit
);

    logic [DW:0] rem_sh;
    logic [DW:0] diff;

    // Extra bit on the shifted remainder keeps the compare exact; result always fits DW bits.
    always_comb begin
        rem_sh   = {rem, in_bit};
        diff     = rem_sh - {1'b0, d};
        q_bit    = (rem_sh >= {1'b0, d});
        rem_next = q_bit ? diff[DW-1:0] : rem_sh[DW-1:0];
    end

endmodule

// File: rtl/div128by64_m.sv
// Sequential unsigned divider: 2*DW-bit dividend by DW-bit divisor, one quotient bit per clock.
module div128by64_m #(
    parameter int unsigned DW = math_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            ready,
    input  logic [2*DW-1:0] n,
    input  logic [DW-1:0]   d,
    output logic [2*DW-1:0] q,
    output logic [DW-1:0]   r,
    output logic            dz
);

    import math_pkg::*;

    localparam int unsigned CW = ctr_width(2 * DW);

    div_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [2*DW-1:0] sr_q, sr_d;
    logic [DW-1:0]   dv_q, dv_d;
    logic            zp_q, zp_d;
    logic            ready_q, ready_d;
    logic [2*DW-1:0] q_q, q_d;
    logic [DW-1:0]   r_q, r_d;
    logic            dz_q, dz_d;

    logic [DW-1:0]   step_rem;
    logic            step_q;

    div_step_m #(.DW(DW)) u_step (
        .rem      (rem_q),
        .in_bit   (sr_q[2*DW-1]),
        .d        (dv_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // State and datapath registers; reset clears the result and aborts any division.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            sr_q    <= '0;
            dv_q    <= '0;
            zp_q    <= 1'b0;
            ready_q <= 1'b1;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            sr_q    <= sr_d;
            dv_q    <= dv_d;
            zp_q    <= zp_d;
            ready_q <= ready_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state: accept, divide-by-zero shortcut (one cycle), or one restoring iteration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        sr_d    = sr_q;
        dv_d    = dv_q;
        zp_d    = 1'b0;
        ready_d = ready_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        unique case (state_q)
            IDLE: begin
                if (zp_q) begin
                    q_d     = '1;
                    r_d     = sr_q[DW-1:0];
                    dz_d    = 1'b1;
                    ready_d = 1'b1;
                end else if (ready_q && start) begin
                    ready_d = 1'b0;
                    sr_d    = n;
                    dv_d    = d;
                    rem_d   = '0;
                    if (d != '0) begin
                        state_d = RUN;
                        cnt_d   = CW'(2 * DW - 1);
                    end else begin
                        zp_d = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = step_rem;
                sr_d  = {sr_q[2*DW-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    q_d     = {sr_q[2*DW-2:0], step_q};
                    r_d     = step_rem;
                    dz_d    = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready = ready_q;
    assign q     = q_q;
    assign r     = r_q;
    assign dz    = dz_q;

endmodule

// File: tb/tb_div128by64_m.sv
// Directed bench for div128by64_m: latency, full range, divide-by-zero, handshake, reset abort.
module tb_div128by64_m;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         ready;
    logic [127:0] n = '0;
    logic [63:0]  d = '0;
    logic [127:0] q;
    logic [63:0]  r;
    logic         dz;

    int checks = 0;
    int failures = 0;

    div128by64_m #(.DW(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .n     (n),
        .d     (d),
        .q     (q),
        .r     (r),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Counts edges until ready rises; called at a falling edge.
    task automatic wait_ready(output int lat);
        lat = 0;
        while (ready !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 400) begin
            checks++;
            failures++;
            $display("FAIL timeout ready=%b after %0d cycles", ready, lat);
        end
    endtask

    // Launch one operation from a falling edge; returns at the falling edge after acceptance.
    task automatic go(input logic [127:0] nn, input logic [63:0] dd);
        n = nn;
        d = dd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", 128'(ready), 128'(0));
    endtask

    initial begin
        int lat;
        logic [63:0]  a, b, c;
        logic [127:0] p;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_q", q, 128'(0));
        chk("rst_r", 128'(r), 128'(0));
        chk("rst_dz", 128'(dz), 128'(0));
        rst = 1'b1;
        @(negedge clk);

        // Basic: 100 / 7
        go(128'h64, 64'h7);
        wait_ready(lat);
        chk("basic_lat", 128'(lat), 128'(128));
        chk("basic_q", q, 128'hE);
        chk("basic_r", 128'(r), 128'h2);
        chk("basic_dz", 128'(dz), 128'(0));

        // Outputs hold across idle cycles
        repeat (5) @(negedge clk);
        chk("hold_ready", 128'(ready), 128'(1));
        chk("hold_q", q, 128'hE);
        chk("hold_r", 128'(r), 128'h2);

        // Full range
        go({128{1'b1}}, 64'h1);
        wait_ready(lat);
        chk("full_d1_q", q, {128{1'b1}});
        chk("full_d1_r", 128'(r), 128'(0));
        go({128{1'b1}}, {64{1'b1}});
        wait_ready(lat);
        chk("full_dmax_q", q, 128'h1_0000_0000_0000_0001);
        chk("full_dmax_r", 128'(r), 128'(0));

        // Divide by zero, then a normal division clears dz
        go(128'h1234_5678_9ABC_DEF0_0000_0000_0000_0005, 64'h0);
        wait_ready(lat);
        chk("dz_lat", 128'(lat), 128'(1));
        chk("dz_flag", 128'(dz), 128'(1));
        chk("dz_q", q, {128{1'b1}});
        chk("dz_r", 128'(r), 128'h5);
        go(128'd9, 64'd3);
        wait_ready(lat);
        chk("after_dz_q", q, 128'd3);
        chk("after_dz_r", 128'(r), 128'(0));
        chk("after_dz_dz", 128'(dz), 128'(0));

        // Round trip: (a*b)/b and (a*b+c)/b with c < b
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} | 64'h1;
            c = {$urandom, $urandom} % b;
            p = 128'(a) * 128'(b);
            go(p, b);
            wait_ready(lat);
            chk("rt_q", q, 128'(a));
            chk("rt_r", 128'(r), 128'(0));
            go(p + 128'(c), b);
            wait_ready(lat);
            chk("rtc_q", q, 128'(a));
            chk("rtc_r", 128'(r), 128'(c));
        end

        // Start pulsed while busy and inputs changed after acceptance: 1000 / 7
        go(128'd1000, 64'd7);
        repeat (49) @(negedge clk);
        chk("busy_mid_q", q, 128'(a));
        n = 128'd5;
        d = 64'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = '1;
        d = 64'd3;
        wait_ready(lat);
        chk("busy_start_lat", 128'(lat), 128'(78));
        chk("busy_start_q", q, 128'd142);
        chk("busy_start_r", 128'(r), 128'd6);

        // Start held high: back-to-back, each result visible for one cycle
        n = 128'd200;
        d = 64'd9;
        start = 1'b1;
        @(negedge clk);
        chk("held_busy0", 128'(ready), 128'(0));
        wait_ready(lat);
        chk("held_lat0", 128'(lat), 128'(128));
        chk("held_q0", q, 128'd22);
        chk("held_r0", 128'(r), 128'd2);
        n = 128'd20;
        d = 64'd4;
        @(negedge clk);
        chk("held_busy1", 128'(ready), 128'(0));
        chk("held_hold_q", q, 128'd22);
        wait_ready(lat);
        chk("held_lat1", 128'(lat), 128'(128));
        chk("held_q1", q, 128'd5);
        chk("held_r1", 128'(r), 128'd0);
        start = 1'b0;
        @(negedge clk);
        chk("held_release_ready", 128'(ready), 128'(1));
        chk("held_release_q", q, 128'd5);

        // Reset mid-operation aborts asynchronously
        go(128'd100000, 64'd3);
        repeat (59) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_ready", 128'(ready), 128'(1));
        chk("abort_q", q, 128'(0));
        chk("abort_r", 128'(r), 128'(0));
        chk("abort_dz", 128'(dz), 128'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        go(128'd100, 64'd10);
        wait_ready(lat);
        chk("post_abort_lat", 128'(lat), 128'(128));
        chk("post_abort_q", q, 128'd10);
        chk("post_abort_r", 128'(r), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
